// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC reader: FSM encoding, frame layout, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_adc_pkg;

  // FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default frame geometry
  localparam int FRAME_BITS_DEF = 34;
  localparam int SAMPLE_W_DEF   = 14;

  // Bit positions of each channel inside the received frame (MSB first, 33..0)
  localparam int CH0_MSB = 31;
  localparam int CH0_LSB = 18;
  localparam int CH1_MSB = 15;
  localparam int CH1_LSB = 2;

  // Counter width able to hold values 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_adc_reader_sck_gen.sv
// SPI clock generator: clk/2 toggle while enabled, forced low otherwise, with edge flags.
// Latency: o_sck is registered; o_rise/o_fall flag the edge taken on the coming clk edge.
// Backpressure: none; i_en alone gates the toggle.
module spi_sck_gen (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  logic r_sck;

  // Toggle every clk while enabled; park low when disabled or in reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sck <= 1'b0;
    end else if (i_en) begin
      r_sck <= ~r_sck;
    end else begin
      r_sck <= 1'b0;
    end
  end

  assign o_sck  = r_sck;
  assign o_rise = i_en & ~r_sck;
  assign o_fall = i_en &  r_sck;

endmodule

// File: rtl/spi_adc_reader.sv
// SPI master reading one two-channel ADC frame per start request (optional SPI_ADC_READER_OVERRUN_EN adds sticky overrun flag).
// Latency: start accepted -> data_valid after 1 + CONV_CYCLES + 2*FRAME_BITS clk cycles.
// Backpressure: none; start is only sampled in IDLE, starts while busy are dropped.
module spi_adc_reader
  import spi_adc_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int CONV_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                spimiso,
  output logic                spisck,
  output logic                ad_conv,
  output logic                busy,
  output logic [SAMPLE_W-1:0] sample_ch0,
  output logic [SAMPLE_W-1:0] sample_ch1,
`ifdef SPI_ADC_READER_OVERRUN_EN
  output logic                overrun,
`endif
  output logic                data_valid
);

  localparam int BCW  = cnt_w(FRAME_BITS);
  localparam int CCW  = cnt_w(CONV_CYCLES);
  // The two leading dummy bits simply fall off the top of the shifter.
  localparam int SR_W = CH0_MSB + 1;

  state_t              r_state;
  state_t              w_next_state;
  logic [CCW-1:0]      r_conv_cnt;
  logic [BCW-1:0]      r_bit_cnt;
  logic [SR_W-1:0]     r_sr;
  logic                r_ad_conv;
  logic                r_data_valid;
  logic [SAMPLE_W-1:0] r_ch0;
  logic [SAMPLE_W-1:0] r_ch1;

  logic w_sck;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_sck_en;
  logic w_start_acc;
  logic w_ad_conv_nxt;
  logic w_dv_nxt;

  assign w_sck_en    = (r_state == SHIFT);
  assign w_start_acc = (r_state == IDLE) && start;

  spi_sck_gen u_sck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_sck_en),
    .o_sck   (w_sck),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and next values of the registered strobes
  always_comb begin
    w_next_state  = r_state;
    w_ad_conv_nxt = 1'b0;
    w_dv_nxt      = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next_state = CONV;
      CONV:  if (r_conv_cnt == '0) w_next_state = SHIFT;
      // Exit on the final high phase; the toggle itself brings spisck back low.
      SHIFT: if ((r_bit_cnt == '0) && w_sck) w_next_state = DONE;
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    w_ad_conv_nxt = (w_next_state == CONV);
    w_dv_nxt      = (w_next_state == DONE);
  end

  // Conversion and bit counters, input shifter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_conv_cnt <= '0;
      r_bit_cnt  <= BCW'(FRAME_BITS - 1);
      r_sr       <= '0;
    end else begin
      if (w_start_acc) begin
        r_conv_cnt <= CCW'(CONV_CYCLES - 1);
      end else if ((r_state == CONV) && (r_conv_cnt != '0)) begin
        r_conv_cnt <= r_conv_cnt - 1'b1;
      end
      // Reloaded only on entry to SHIFT; saturates at zero
      if ((r_state == CONV) && (w_next_state == SHIFT)) begin
        r_bit_cnt <= BCW'(FRAME_BITS - 1);
      end else if (w_sck_fall && (r_bit_cnt != '0)) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      if (w_sck_rise) begin
        r_sr <= {r_sr[SR_W-2:0], spimiso};
      end
    end
  end

  // Registered outputs: convert strobe, valid pulse and sample holding registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ad_conv    <= 1'b0;
      r_data_valid <= 1'b0;
      r_ch0        <= '0;
      r_ch1        <= '0;
    end else begin
      r_ad_conv    <= w_ad_conv_nxt;
      r_data_valid <= w_dv_nxt;
      if (w_dv_nxt) begin
        r_ch0 <= SAMPLE_W'(r_sr[CH0_MSB:CH0_LSB]);
        r_ch1 <= SAMPLE_W'(r_sr[CH1_MSB:CH1_LSB]);
      end
    end
  end

`ifdef SPI_ADC_READER_OVERRUN_EN
  logic r_overrun;

  // Sticky flag for starts dropped while busy; an accepted start clears it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_start_acc) begin
      r_overrun <= 1'b0;
    end else if (start && (r_state != IDLE) && (r_state != DONE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

  assign spisck     = w_sck;
  assign ad_conv    = r_ad_conv;
  assign busy       = (r_state != IDLE);
  assign sample_ch0 = r_ch0;
  assign sample_ch1 = r_ch1;
  assign data_valid = r_data_valid;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Testbench for spi_adc_reader: default DUT plus a CONV_CYCLES=1 variant, each fed by an ADC model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_adc_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start0, start1;
  logic miso0 = 1'b0;
  logic miso1 = 1'b0;

  logic        spisck0, ad_conv0, busy0, dv0;
  logic [13:0] ch0_0, ch1_0;
  logic        spisck1, ad_conv1, busy1, dv1;
  logic [13:0] ch0_1, ch1_1;
`ifdef SPI_ADC_READER_OVERRUN_EN
  logic overrun0, overrun1;
`endif

  spi_adc_reader u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start0),
    .spimiso    (miso0),
    .spisck     (spisck0),
    .ad_conv    (ad_conv0),
    .busy       (busy0),
    .sample_ch0 (ch0_0),
    .sample_ch1 (ch1_0),
`ifdef SPI_ADC_READER_OVERRUN_EN
    .overrun    (overrun0),
`endif
    .data_valid (dv0)
  );

  spi_adc_reader #(.CONV_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start1),
    .spimiso    (miso1),
    .spisck     (spisck1),
    .ad_conv    (ad_conv1),
    .busy       (busy1),
    .sample_ch0 (ch0_1),
    .sample_ch1 (ch1_1),
`ifdef SPI_ADC_READER_OVERRUN_EN
    .overrun    (overrun1),
`endif
    .data_valid (dv1)
  );

  // ADC models: latch the frame on convert, present MSB, advance after each SCK fall
  logic [33:0] frame0 = '0;
  logic [33:0] frame1 = '0;
  logic [33:0] cur0 = '0;
  logic [33:0] cur1 = '0;
  int idx0 = 33;
  int idx1 = 33;

  always @(posedge ad_conv0 or negedge spisck0) begin
    if (ad_conv0) begin
      cur0 = frame0;
      idx0 = 33;
    end else if (idx0 > 0) begin
      idx0 = idx0 - 1;
    end
    miso0 = cur0[idx0];
  end

  always @(posedge ad_conv1 or negedge spisck1) begin
    if (ad_conv1) begin
      cur1 = frame1;
      idx1 = 33;
    end else if (idx1 > 0) begin
      idx1 = idx1 - 1;
    end
    miso1 = cur1[idx1];
  end

  // Cumulative event counters
  int conv_cnt0 = 0, dv_cnt0 = 0, rise_cnt0 = 0;
  int conv_cnt1 = 0, dv_cnt1 = 0, rise_cnt1 = 0;

  always @(posedge clk) begin
    if (ad_conv0) conv_cnt0++;
    if (dv0)      dv_cnt0++;
    if (ad_conv1) conv_cnt1++;
    if (dv1)      dv_cnt1++;
  end
  always @(posedge spisck0) rise_cnt0++;
  always @(posedge spisck1) rise_cnt1++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete frame on DUT sel; called just after a negedge
  task automatic run_frame(input int sel, input string name, input logic [33:0] f,
                           input logic [13:0] e0, input logic [13:0] e1,
                           input int e_lat, input int e_conv);
    int c0, r0, d0, lat;
    if (sel == 1) frame1 = f; else frame0 = f;
    c0 = (sel == 1) ? conv_cnt1 : conv_cnt0;
    r0 = (sel == 1) ? rise_cnt1 : rise_cnt0;
    d0 = (sel == 1) ? dv_cnt1   : dv_cnt0;
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 1;
    while (!((sel == 1) ? dv1 : dv0) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!((sel == 1) ? dv1 : dv0)) lat = -1;
    chk({name, " latency"}, lat, e_lat);
    chk({name, " ch0"}, int'((sel == 1) ? ch0_1 : ch0_0), int'(e0));
    chk({name, " ch1"}, int'((sel == 1) ? ch1_1 : ch1_0), int'(e1));
    @(negedge clk);
    chk({name, " dv single"}, int'((sel == 1) ? dv1 : dv0), 0);
    chk({name, " busy after"}, int'((sel == 1) ? busy1 : busy0), 0);
    chk({name, " ad_conv cycles"}, ((sel == 1) ? conv_cnt1 : conv_cnt0) - c0, e_conv);
    chk({name, " sck rises"}, ((sel == 1) ? rise_cnt1 : rise_cnt0) - r0, 34);
    chk({name, " dv pulses"}, ((sel == 1) ? dv_cnt1 : dv_cnt0) - d0, 1);
  endtask

  typedef struct {
    string       name;
    logic [33:0] frame;
    logic [13:0] ch0;
    logic [13:0] ch1;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd, d0, unstable;
    int dcyc[3];
    logic [13:0] p0, p1;

    tbl[0] = '{"basic",   34'b00_01100110011001_00_10011001100110_00, 14'h1999, 14'h2666};
    tbl[1] = '{"extreme", {2'b11, 14'h1FFF, 2'b11, 14'h2000, 2'b11},   14'h1FFF, 14'h2000};
    tbl[2] = '{"swapped", {2'b10, 14'h2000, 2'b01, 14'h1FFF, 2'b10},   14'h2000, 14'h1FFF};
    tbl[3] = '{"dummyonly", {2'b11, 14'h0000, 2'b11, 14'h0000, 2'b11}, 14'h0000, 14'h0000};

    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset spisck", int'(spisck0), 0);
    chk("reset ad_conv", int'(ad_conv0), 0);
    chk("reset busy", int'(busy0), 0);
    chk("reset data_valid", int'(dv0), 0);
    chk("reset ch0", int'(ch0_0), 0);
    chk("reset ch1", int'(ch1_0), 0);
`ifdef SPI_ADC_READER_OVERRUN_EN
    chk("reset overrun", int'(overrun0), 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      run_frame(0, tbl[i].name, tbl[i].frame, tbl[i].ch0, tbl[i].ch1, 71, 2);
      @(negedge clk);
    end

    // Start held high: three back-to-back frames, 72 cycles apart
    frame0   = tbl[1].frame;
    p0       = ch0_0;
    p1       = ch1_0;
    unstable = 0;
    n        = 0;
    nd       = 0;
    dcyc     = '{0, 0, 0};
    start0   = 1'b1;
    while (nd < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (dv0) begin
        dcyc[nd] = n;
        chk("contig ch0", int'(ch0_0), int'(tbl[nd + 1].ch0));
        chk("contig ch1", int'(ch1_0), int'(tbl[nd + 1].ch1));
        nd++;
        if (nd < 3) frame0 = tbl[nd + 1].frame;
      end else if (ch0_0 !== p0 || ch1_0 !== p1) begin
        unstable++;
      end
      p0 = ch0_0;
      p1 = ch1_0;
    end
    start0 = 1'b0;
    chk("contig frames", nd, 3);
    chk("contig first latency", dcyc[0], 71);
    chk("contig spacing 1-2", dcyc[1] - dcyc[0], 72);
    chk("contig spacing 2-3", dcyc[2] - dcyc[1], 72);
    chk("contig samples stable", unstable, 0);
    repeat (3) @(negedge clk);

    // Start pulsed during SHIFT cycle 20 is ignored
    frame0 = tbl[0].frame;
    d0     = dv_cnt0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 1;
    while (n < 23) begin
      @(negedge clk);
      n++;
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n++;
`ifdef SPI_ADC_READER_OVERRUN_EN
    chk("busy start overrun set", int'(overrun0), 1);
`endif
    while (!dv0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy start latency", dv0 ? n : -1, 71);
    chk("busy start ch0", int'(ch0_0), int'(tbl[0].ch0));
    repeat (150) @(negedge clk);
    chk("busy start no extra frame", dv_cnt0 - d0, 1);
    chk("busy start idle", int'(busy0), 0);
`ifdef SPI_ADC_READER_OVERRUN_EN
    chk("overrun sticky", int'(overrun0), 1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("overrun cleared by start", int'(overrun0), 0);
    n = 1;
    while (!dv0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
`endif

    // Reset asserted mid-SHIFT while bit_count is 10 and spisck is high
    frame0 = tbl[2].frame;
    d0     = dv_cnt0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midshift spisck high", int'(spisck0), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset spisck", int'(spisck0), 0);
    chk("midreset ad_conv", int'(ad_conv0), 0);
    chk("midreset busy", int'(busy0), 0);
    chk("midreset data_valid", int'(dv0), 0);
    chk("midreset ch0", int'(ch0_0), 0);
    chk("midreset ch1", int'(ch1_0), 0);
`ifdef SPI_ADC_READER_OVERRUN_EN
    chk("midreset overrun", int'(overrun0), 0);
`endif
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midreset no data_valid", dv_cnt0 - d0, 0);
    run_frame(0, "after reset", tbl[1].frame, tbl[1].ch0, tbl[1].ch1, 71, 2);
    @(negedge clk);

    // CONV_CYCLES=1 variant
    run_frame(1, "conv1", tbl[0].frame, tbl[0].ch0, tbl[0].ch1, 70, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
